// File: rtl/multiexp_pnt_scl_feeder.sv
// Point/scalar feeder for the G2 multiexp core: buffers N {point, scalar} pairs
// from the host stream, then replays the whole list once per key bit.
module multiexp_pnt_scl_feeder #(
  parameter int NUM_MAX  = 16,
  parameter int DAT_BITS = 1792,
  parameter int KEY_BITS = 256,
  parameter int CTL_BITS = 9,
  parameter int MOD_BITS = $clog2(DAT_BITS/8)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [$clog2(NUM_MAX):0]   i_num_in,
  // host load stream (sink)
  input  logic                       i_pnt_scl_val,
  input  logic                       i_pnt_scl_sop,
  input  logic                       i_pnt_scl_eop,
  input  logic [DAT_BITS-1:0]        i_pnt_scl_dat,
  output logic                       i_pnt_scl_rdy,
  // replay stream to the multiexp core (source)
  output logic                       o_pnt_scl_val,
  output logic                       o_pnt_scl_sop,
  output logic                       o_pnt_scl_eop,
  output logic                       o_pnt_scl_err,
  output logic [MOD_BITS-1:0]        o_pnt_scl_mod,
  output logic [CTL_BITS-1:0]        o_pnt_scl_ctl,
  output logic [DAT_BITS-1:0]        o_pnt_scl_dat,
  input  logic                       o_pnt_scl_rdy,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int NW = $clog2(NUM_MAX) + 1;
  localparam int IW = $clog2(NUM_MAX);
  localparam int PB = $clog2(KEY_BITS);

  typedef enum logic [1:0] {IDLE, LOAD, REPLAY, DONE} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       num_q;
  logic [IW-1:0]       wr_idx, rd_idx;
  logic [PB-1:0]       pass_q;
  logic                issued_last;
  logic                err_q;
  logic [DAT_BITS-1:0] mem [NUM_MAX];

  logic                in_xfer, out_xfer, num_ok, wr_last, rd_last, pass_last;
  logic                load_en;
  logic [DAT_BITS-1:0] load_dat;
  logic                unused_sop;

  assign unused_sop    = i_pnt_scl_sop;
  assign o_pnt_scl_mod = '0;
  assign o_pnt_scl_err = 1'b0;
  assign o_err         = err_q;

  assign in_xfer   = i_pnt_scl_val && i_pnt_scl_rdy;
  assign out_xfer  = o_pnt_scl_val && o_pnt_scl_rdy;
  assign num_ok    = (i_num_in != '0) && (i_num_in <= NW'(NUM_MAX));
  assign wr_last   = ({1'b0, wr_idx} == num_q - NW'(1));
  assign rd_last   = ({1'b0, rd_idx} == num_q - NW'(1));
  assign pass_last = (pass_q == PB'(KEY_BITS - 1));

  // The first replay beat is loaded on the same edge that accepts the last load
  // beat, so a single-pair job has to forward it straight from the input.
  assign load_en = (state_q == LOAD && in_xfer && i_pnt_scl_eop && wr_last) ||
                   (state_q == REPLAY && !issued_last && (!o_pnt_scl_val || o_pnt_scl_rdy));
  assign load_dat = (state_q == LOAD && wr_idx == '0) ? i_pnt_scl_dat : mem[rd_idx];

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start && num_ok) state_d = LOAD;
      LOAD:    if (in_xfer && (i_pnt_scl_eop || wr_last))
                 state_d = (i_pnt_scl_eop && wr_last) ? REPLAY : IDLE;
      REPLAY:  if (out_xfer && o_pnt_scl_eop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_pnt_scl_rdy = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      LOAD:    begin i_pnt_scl_rdy = 1'b1; o_busy = 1'b1; end
      REPLAY:  o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the pair buffer has no reset; its contents are don't-care until loaded.
  always_ff @(posedge i_clk) begin
    if (state_q == LOAD && in_xfer) mem[wr_idx] <= i_pnt_scl_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_q       <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      pass_q      <= '0;
      issued_last <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE && i_start && !num_ok) ||
               (state_q == LOAD && in_xfer && (i_pnt_scl_eop != wr_last));
      if (state_q == IDLE && i_start && num_ok) begin
        num_q       <= i_num_in;
        wr_idx      <= '0;
        rd_idx      <= '0;
        pass_q      <= '0;
        issued_last <= 1'b0;
      end
      if (state_q == LOAD && in_xfer) wr_idx <= wr_idx + IW'(1);
      if (load_en) begin
        issued_last <= pass_last && rd_last;
        if (rd_last) begin
          rd_idx <= '0;
          pass_q <= pass_q + PB'(1);
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end
    end
  end

  // Output register: reloads whenever empty or draining, so no bubbles at rdy=1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pnt_scl_val <= 1'b0;
      o_pnt_scl_sop <= 1'b0;
      o_pnt_scl_eop <= 1'b0;
      o_pnt_scl_ctl <= '0;
      o_pnt_scl_dat <= '0;
    end else if (load_en) begin
      o_pnt_scl_val <= 1'b1;
      o_pnt_scl_sop <= (pass_q == '0) && (rd_idx == '0);
      o_pnt_scl_eop <= pass_last && rd_last;
      o_pnt_scl_ctl <= CTL_BITS'(pass_q);
      o_pnt_scl_dat <= load_dat;
    end else if (out_xfer) begin
      o_pnt_scl_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Scoreboard bench for multiexp_pnt_scl_feeder: stimulus queues expected replay
// beats, an independent monitor pops and compares each output transfer.
module tb_multiexp_pnt_scl_feeder;

  localparam int NUM_MAX  = 16;
  localparam int DAT_BITS = 1792;
  localparam int KEY_BITS = 256;
  localparam int CTL_BITS = 9;
  localparam int MOD_BITS = 8;
  localparam int NW       = $clog2(NUM_MAX) + 1;

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;
    logic                sop;
    logic                eop;
    logic                err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start = 1'b0;
  logic [NW-1:0]       num_in = '0;
  logic                i_val = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_rdy;
  logic [DAT_BITS-1:0] i_dat = '0;
  logic                o_val, o_sop, o_eop, o_serr;
  logic [MOD_BITS-1:0] o_mod;
  logic [CTL_BITS-1:0] o_ctl;
  logic [DAT_BITS-1:0] o_dat;
  logic                o_rdy = 1'b1;
  logic                busy, done, err;

  multiexp_pnt_scl_feeder #(
    .NUM_MAX(NUM_MAX), .DAT_BITS(DAT_BITS), .KEY_BITS(KEY_BITS),
    .CTL_BITS(CTL_BITS), .MOD_BITS(MOD_BITS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_in(num_in),
    .i_pnt_scl_val(i_val), .i_pnt_scl_sop(i_sop), .i_pnt_scl_eop(i_eop),
    .i_pnt_scl_dat(i_dat), .i_pnt_scl_rdy(i_rdy),
    .o_pnt_scl_val(o_val), .o_pnt_scl_sop(o_sop), .o_pnt_scl_eop(o_eop),
    .o_pnt_scl_err(o_serr), .o_pnt_scl_mod(o_mod), .o_pnt_scl_ctl(o_ctl),
    .o_pnt_scl_dat(o_dat), .o_pnt_scl_rdy(o_rdy),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  logic [DAT_BITS-1:0] job_dat [NUM_MAX];

  bit    mon_en = 1'b0;
  bit    rand_rdy = 1'b0;
  bit    expect_done = 1'b0;
  bit    stall_q = 1'b0;
  bit    in_job = 1'b0;
  beat_t hold;
  int    beats_rx = 0;
  int    bubbles = 0;
  int    jobs_done = 0;
  int    job_target = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold(input logic [DAT_BITS-1:0] d);
    logic [31:0] r = '0;
    for (int k = 0; k < DAT_BITS/32; k++) r ^= d[k*32 +: 32];
    return r;
  endfunction

  function automatic logic [63:0] pack(input beat_t b);
    return {7'b0, b.ctl, b.mod, 5'b0, b.sop, b.eop, b.err, fold(b.dat)};
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.dat = o_dat; b.ctl = o_ctl; b.mod = o_mod;
    b.sop = o_sop; b.eop = o_eop; b.err = o_serr;
    return b;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    beat_t a, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = cur_beat();
        if (expect_done) begin
          check("done_pulse", done && !o_val, {62'b0, done, o_val}, 64'h2);
          expect_done = 1'b0;
          jobs_done++;
        end else if (done) begin
          check("spurious_done", 1'b0, 64'h1, 64'h0);
        end
        if (stall_q)
          check("stall_hold", o_val && a == hold, pack(a), pack(hold));
        if (in_job && !o_val) bubbles++;
        if (o_val && o_rdy) begin
          beats_rx++;
          if (sb.size() == 0) begin
            check("unexpected_beat", 1'b0, pack(a), 64'h0);
          end else begin
            e = sb.pop_front();
            check("beat", a == e, pack(a), pack(e));
            if (e.eop) expect_done = 1'b1;
          end
          if (o_sop) in_job = 1'b1;
          if (o_eop) in_job = 1'b0;
        end
        stall_q = o_val && !o_rdy;
        hold    = a;
      end
    end
  end

  // Core-side ready: held high, or 50% random backpressure.
  initial forever begin
    @(posedge clk);
    #1 o_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < DAT_BITS/32; k++) job_dat[i][k*32 +: 32] = $urandom;
  endtask

  task automatic push_expected(input int n);
    beat_t b;
    for (int p = 0; p < KEY_BITS; p++)
      for (int r = 0; r < n; r++) begin
        b.dat = job_dat[r];
        b.ctl = CTL_BITS'(p);
        b.mod = '0;
        b.sop = (p == 0 && r == 0);
        b.eop = (p == KEY_BITS-1 && r == n-1);
        b.err = 1'b0;
        sb.push_back(b);
      end
  endtask

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_in = NW'(n);
    @(posedge clk); #1;
    start = 1'b0; num_in = '0;
  endtask

  task automatic send_beat(input logic [DAT_BITS-1:0] d, input bit sop, input bit eop);
    int t = 0;
    i_val = 1'b1; i_dat = d; i_sop = sop; i_eop = eop;
    @(negedge clk);
    while (!i_rdy && t < 50) begin @(negedge clk); t++; end
    if (!i_rdy) check("load_rdy_timeout", 1'b0, 64'h0, 64'h1);
    @(posedge clk); #1;
    i_val = 1'b0; i_eop = 1'b0; i_sop = 1'b0;
  endtask

  task automatic load(input int n, input int eop_pos);
    for (int i = 0; i < n; i++) begin
      send_beat(job_dat[i], i == 0, i == eop_pos);
      if (i == eop_pos) break;
    end
  endtask

  task automatic wait_jobs(input int limit);
    int t = 0;
    while (jobs_done < job_target && t < limit) begin @(posedge clk); t++; end
    check("job_complete", jobs_done >= job_target, 64'(jobs_done), 64'(job_target));
    #1;
  endtask

  task automatic run_job(input int n, input bit poke_start);
    fill(n);
    push_expected(n);
    start_job(n);
    load(n, n-1);
    if (poke_start) begin
      start = 1'b1; num_in = '0;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("start_ignored_busy", !err && busy, {62'b0, err, busy}, 64'h1);
      @(posedge clk); #1;
    end
    job_target++;
    wait_jobs(n*KEY_BITS*4 + 100);
    check("sb_empty", sb.size() == 0, 64'(sb.size()), 64'h0);
    check("no_bubbles", bubbles == 0, 64'(bubbles), 64'h0);
  endtask

  initial begin
    int base;
    int t;
    // T1: reset values
    #23;
    check("reset_outputs",
          {o_val, o_sop, o_eop, o_serr, |o_mod, |o_ctl, |o_dat, i_rdy, busy, done, err} == '0,
          {53'b0, o_val, o_sop, o_eop, o_serr, |o_mod, |o_ctl, |o_dat, i_rdy, busy, done, err},
          64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {o_val, i_rdy, busy, done, err} == '0,
          {59'b0, o_val, i_rdy, busy, done, err}, 64'h0);

    // T2: full job N=4, rdy held high, 1024 back-to-back beats
    base = beats_rx;
    run_job(4, 1'b0);
    check("t2_beat_count", beats_rx - base == 4*KEY_BITS, 64'(beats_rx - base), 64'(4*KEY_BITS));

    // T3: 50% backpressure, N=3
    rand_rdy = 1'b1;
    base = beats_rx;
    run_job(3, 1'b0);
    check("t3_beat_count", beats_rx - base == 3*KEY_BITS, 64'(beats_rx - base), 64'(3*KEY_BITS));
    rand_rdy = 1'b0;

    // T4: rejected starts
    start_job(0);
    @(negedge clk);
    check("err_num_zero", err && !i_rdy && !busy, {61'b0, err, i_rdy, busy}, 64'h4);
    @(negedge clk);
    check("err_one_cycle", !err && !i_rdy, {62'b0, err, i_rdy}, 64'h0);
    start_job(NUM_MAX + 1);
    @(negedge clk);
    check("err_num_over", err && !i_rdy && !busy, {61'b0, err, i_rdy, busy}, 64'h4);
    @(negedge clk);
    check("err_over_one_cycle", !err && !i_rdy, {62'b0, err, i_rdy}, 64'h0);

    // T5: framing error (eop on 2nd beat of N=4), then a clean N=2 job
    base = beats_rx;
    fill(4);
    start_job(4);
    load(4, 1);
    @(negedge clk);
    check("framing_err", err && !busy && !i_rdy, {61'b0, err, busy, i_rdy}, 64'h4);
    repeat (5) @(posedge clk);
    #1;
    check("framing_no_output", beats_rx == base, 64'(beats_rx - base), 64'h0);
    run_job(2, 1'b0);

    // Boundaries: N=NUM_MAX (with an ignored start mid-job) and N=1
    run_job(NUM_MAX, 1'b1);
    run_job(1, 1'b0);

    // Reset mid-REPLAY drops val at once; a rerun must still be clean
    base = beats_rx;
    fill(2);
    push_expected(2);
    start_job(2);
    load(2, 1);
    t = 0;
    while (beats_rx < base + 10 && t < 200) begin @(posedge clk); t++; end
    check("replay_started", beats_rx >= base + 10, 64'(beats_rx - base), 64'd10);
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("reset_drops_val", {o_val, busy, i_rdy} == '0, {61'b0, o_val, busy, i_rdy}, 64'h0);
    sb.delete();
    expect_done = 1'b0; stall_q = 1'b0; in_job = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    run_job(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
